ov7670_config_sequencer: RTL and testbench

- Sequences OV7670 bring-up: drives camera power-down/reset pins, then walks a register-init table and issues each entry as an SCCB write through a handshake to the SCCB master.
- Sits between the camera controller's start logic and the SCCB master.
- Raises a done flag that gates frame capture.
- Supports in-table delay entries, end-of-table sentinel, and bounded retry on NACK.

---
 rtl/ov7670_config_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer.sv
// OV7670 bring-up sequencer: drives the camera power-down/reset pins, then replays a
// register-init table as SCCB writes, with in-table delays and bounded NACK retry.
module ov7670_config_sequencer #(
    parameter int ADDR_W        = 8,
    parameter int RESET_CYCLES  = 25000,
    parameter int SETTLE_CYCLES = 25000,
    parameter int DELAY_CYCLES  = 250000,
    parameter int MAX_RETRY     = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              sccb_valid_o,
    input  logic              sccb_ready_i,
    output logic [7:0]        sccb_reg_o,
    output logic [7:0]        sccb_val_o,
    input  logic              sccb_done_i,
    input  logic              sccb_nack_i,
    output logic              ov7670_reset_o,
    output logic              ov7670_pwrdn_o,
    output logic              busy_o,
    output logic              config_done_o,
    output logic              fault_o,
    output logic [ADDR_W-1:0] fault_addr_o
);
    localparam int TMAX0 = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int TMAX  = (TMAX0 > DELAY_CYCLES) ? TMAX0 : DELAY_CYCLES;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMR_W-1:0] RESET_LAST  = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(DELAY_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRY);
    localparam logic [15:0]      END_WORD    = 16'hFFFF;
    localparam logic [15:0]      DELAY_WORD  = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_SETTLE, S_FETCH, S_DECODE, S_ISSUE,
        S_WAIT, S_DELAY, S_NEXT, S_DONE, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [RTY_W-1:0]  rty_q, rty_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic [7:0]        sccb_reg_q, sccb_reg_d;
    logic [7:0]        sccb_val_q, sccb_val_d;
    logic              sccb_valid_q, sccb_valid_d;
    logic              ov_reset_q, ov_reset_d;
    logic              ov_pwrdn_q, ov_pwrdn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    // State, shared timer, retry count and all registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            rty_q        <= '0;
            rom_addr_q   <= '0;
            fault_addr_q <= '0;
            sccb_reg_q   <= 8'h00;
            sccb_val_q   <= 8'h00;
            sccb_valid_q <= 1'b0;
            ov_reset_q   <= 1'b0;
            ov_pwrdn_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            rty_q        <= rty_d;
            rom_addr_q   <= rom_addr_d;
            fault_addr_q <= fault_addr_d;
            sccb_reg_q   <= sccb_reg_d;
            sccb_val_q   <= sccb_val_d;
            sccb_valid_q <= sccb_valid_d;
            ov_reset_q   <= ov_reset_d;
            ov_pwrdn_q   <= ov_pwrdn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register in step with it
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        rty_d        = rty_q;
        rom_addr_d   = rom_addr_q;
        fault_addr_d = fault_addr_q;
        sccb_reg_d   = sccb_reg_q;
        sccb_val_d   = sccb_val_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start_i) begin
                    state_d    = S_PWRUP;
                    tmr_d      = '0;
                    rom_addr_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_PWRUP: begin
                if (tmr_q == RESET_LAST) begin
                    tmr_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_FETCH: begin
                rty_d   = '0;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (rom_data_i == END_WORD) begin
                    state_d = S_DONE;
                end else if (rom_data_i == DELAY_WORD) begin
                    tmr_d   = '0;
                    state_d = S_DELAY;
                end else begin
                    sccb_reg_d = rom_data_i[15:8];
                    sccb_val_d = rom_data_i[7:0];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sccb_ready_i) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT: begin
                if (!sccb_done_i) begin
                    state_d = state_q;
                end else if (!sccb_nack_i) begin
                    state_d = S_NEXT;
                end else if (rty_q < RTY_MAX) begin
                    rty_d   = rty_q + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    fault_addr_d = rom_addr_q;
                    state_d      = S_FAULT;
                end
            end
            S_DELAY: begin
                if (tmr_q == DELAY_LAST) begin
                    tmr_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_NEXT: begin
                // The last table slot ends the sequence rather than wrapping to 0
                if (rom_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = S_DONE;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        sccb_valid_d = (state_d == S_ISSUE);
        busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FAULT));
        done_d       = (state_d == S_DONE);
        fault_d      = (state_d == S_FAULT);
        case (state_d)
            S_IDLE: begin
                ov_reset_d = 1'b0;
                ov_pwrdn_d = 1'b1;
            end
            S_PWRUP: begin
                ov_reset_d = 1'b0;
                ov_pwrdn_d = 1'b0;
            end
            S_DONE, S_FAULT: begin
                ov_reset_d = ov_reset_q;
                ov_pwrdn_d = ov_pwrdn_q;
            end
            default: begin
                ov_reset_d = 1'b1;
                ov_pwrdn_d = 1'b0;
            end
        endcase
    end

    assign rom_addr_o     = rom_addr_q;
    assign sccb_valid_o   = sccb_valid_q;
    assign sccb_reg_o     = sccb_reg_q;
    assign sccb_val_o     = sccb_val_q;
    assign ov7670_reset_o = ov_reset_q;
    assign ov7670_pwrdn_o = ov_pwrdn_q;
    assign busy_o         = busy_q;
    assign config_done_o  = done_q;
    assign fault_o        = fault_q;
    assign fault_addr_o   = fault_addr_q;
endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: a registered ROM and a behavioural SCCB slave drive
// the DUT; a table-walk model predicts the write stream, outcome and final address.
`timescale 1ns/1ps
module tb_ov7670_config_sequencer;
    localparam int RESET_CYCLES  = 8;
    localparam int SETTLE_CYCLES = 6;
    localparam int DELAY_CYCLES  = 20;
    localparam int MAX_RETRY     = 3;
    localparam logic [37:0] RST_VEC = {8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_drv = 1'b0;
    logic start_on_done = 1'b0;
    logic start_sig;
    logic [7:0] rom_addr, sccb_reg, sccb_val, fault_addr;
    logic [15:0] rom_data;
    logic sccb_valid, ov_reset, ov_pwrdn, busy, config_done, fault;
    logic sccb_ready = 1'b0;
    logic sccb_done = 1'b0;
    logic sccb_nack = 1'b0;

    logic [15:0] rom_mem [256];
    int nack_plan [256];
    int nack_left [256];
    int ready_delay = 0;
    int done_lat = 1;
    bit start_with_done = 1'b0;
    logic [23:0] acc_q [$];
    logic [23:0] exp_q [$];
    int rise_q [$];
    int done_q [$];
    int cyc = 0, vhigh = 0, lowcnt = 0;
    bit unstable = 1'b0;
    bit exp_fault;
    int exp_final;
    int checks = 0, errors = 0;

    assign start_sig = start_drv | start_on_done;

    ov7670_config_sequencer #(
        .ADDR_W(8), .RESET_CYCLES(RESET_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
        .DELAY_CYCLES(DELAY_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start_sig),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .sccb_valid_o(sccb_valid), .sccb_ready_i(sccb_ready),
        .sccb_reg_o(sccb_reg), .sccb_val_o(sccb_val),
        .sccb_done_i(sccb_done), .sccb_nack_i(sccb_nack),
        .ov7670_reset_o(ov_reset), .ov7670_pwrdn_o(ov_pwrdn),
        .busy_o(busy), .config_done_o(config_done),
        .fault_o(fault), .fault_addr_o(fault_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // SCCB slave plus monitor, acting on falling edges
    initial begin
        bit pv;
        logic [7:0] pa, pr, pvl, ma;
        int mcnt, mwait;
        bit mbusy;
        pv = 1'b0; pa = 8'h00; pr = 8'h00; pvl = 8'h00; ma = 8'h00;
        mcnt = 0; mwait = 0; mbusy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mbusy = 1'b0; mwait = 0; pv = 1'b0;
                sccb_ready = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0; start_on_done = 1'b0;
            end else begin
                sccb_done = 1'b0; sccb_nack = 1'b0; start_on_done = 1'b0;
                if (pv && sccb_ready) begin
                    acc_q.push_back({pa, pr, pvl});
                    ma = pa; mbusy = 1'b1; mcnt = 0; mwait = 0;
                end
                if (pv && sccb_valid && ({sccb_reg, sccb_val} != {pr, pvl})) unstable = 1'b1;
                if (sccb_valid) vhigh++;
                if (sccb_valid && !pv) rise_q.push_back(cyc);
                if (mbusy) begin
                    sccb_ready = 1'b0;
                    mcnt++;
                    if (mcnt >= done_lat) begin
                        sccb_done = 1'b1;
                        if (nack_left[ma] > 0) begin
                            sccb_nack = 1'b1;
                            nack_left[ma]--;
                        end
                        mbusy = 1'b0;
                        done_q.push_back(cyc);
                        start_on_done = start_with_done;
                    end
                end else if (sccb_valid) begin
                    sccb_ready = (mwait >= ready_delay);
                    mwait++;
                end else begin
                    sccb_ready = 1'b0;
                    mwait = 0;
                end
                if (!ov_reset && !ov_pwrdn) lowcnt++;
                pv = sccb_valid; pa = rom_addr; pr = sccb_reg; pvl = sccb_val;
            end
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = 16'hFFFF;
            nack_plan[i] = 0;
        end
    endtask

    // Reference: walk the table by its rules and list every write attempt in order
    task automatic model_run();
        exp_q.delete();
        exp_fault = 1'b0;
        exp_final = 255;
        for (int a = 0; a < 256; a++) begin
            int tries;
            if (rom_mem[a] == 16'hFFFF) begin
                exp_final = a;
                break;
            end
            if (rom_mem[a] != 16'hFFF0) begin
                tries = (nack_plan[a] > MAX_RETRY) ? MAX_RETRY + 1 : nack_plan[a] + 1;
                for (int t = 0; t < tries; t++) exp_q.push_back({8'(a), rom_mem[a]});
                if (nack_plan[a] > MAX_RETRY) begin
                    exp_fault = 1'b1;
                    exp_final = a;
                    break;
                end
            end
        end
    endtask

    task automatic run_seq(input bit wait_end, output bit to);
        @(negedge clk);
        acc_q.delete(); rise_q.delete(); done_q.delete();
        vhigh = 0; lowcnt = 0; unstable = 1'b0;
        for (int i = 0; i < 256; i++) nack_left[i] = nack_plan[i];
        model_run();
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        to = wait_end;
        if (wait_end) begin
            for (int i = 0; i < 20000; i++) begin
                @(negedge clk);
                if (config_done || fault) begin
                    to = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [37:0] obs;
        repeat (3) @(negedge clk);
        obs = {rom_addr, sccb_valid, sccb_reg, sccb_val, ov_reset, ov_pwrdn, busy, config_done, fault, fault_addr};
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, RST_VEC); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        obs = {rom_addr, sccb_valid, sccb_reg, sccb_val, ov_reset, ov_pwrdn, busy, config_done, fault, fault_addr};
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, RST_VEC); end
    endtask

    task automatic test_basic();
        bit to;
        clear_table();
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1100; rom_mem[2] = 16'hFFFF;
        ready_delay = 0; done_lat = 10;
        for (int pass = 0; pass < 2; pass++) begin
            start_with_done = (pass == 1);
            run_seq(1'b1, to);
            checks++;
            if (to) begin errors++; $display("FAIL basic_timeout: pass %0d no done/fault", pass); end
            checks++;
            if (acc_q.size() !== 2) begin
                errors++; $display("FAIL basic_count: pass %0d got %0d writes expected 2", pass, acc_q.size());
            end else begin
                checks++;
                if (acc_q[0] !== 24'h001280 || acc_q[1] !== 24'h011100) begin
                    errors++; $display("FAIL basic_writes: got %h %h expected 001280 011100", acc_q[0], acc_q[1]);
                end
            end
            checks++;
            if ({config_done, busy, fault} !== 3'b100) begin
                errors++; $display("FAIL basic_flags: got done/busy/fault %b expected 100", {config_done, busy, fault});
            end
            checks++;
            if (lowcnt !== RESET_CYCLES) begin
                errors++; $display("FAIL basic_reset_pulse: pass %0d got %0d cycles expected %0d", pass, lowcnt, RESET_CYCLES);
            end
            checks++;
            if ({ov_reset, ov_pwrdn} !== 2'b10) begin
                errors++; $display("FAIL basic_pins: got reset/pwrdn %b expected 10", {ov_reset, ov_pwrdn});
            end
        end
        start_with_done = 1'b0;
    endtask

    task automatic test_ready_stall();
        bit to;
        clear_table();
        rom_mem[0] = 16'h3456;
        ready_delay = 5; done_lat = 3;
        run_seq(1'b1, to);
        checks++;
        if (to || acc_q.size() !== 1) begin
            errors++; $display("FAIL stall_accepts: timeout %0d got %0d accepts expected 1", to, acc_q.size());
        end else begin
            checks++;
            if (acc_q[0] !== 24'h003456) begin errors++; $display("FAIL stall_write: got %h expected 003456", acc_q[0]); end
        end
        checks++;
        if (vhigh !== 6) begin errors++; $display("FAIL stall_valid_len: got %0d cycles expected 6", vhigh); end
        checks++;
        if (unstable) begin errors++; $display("FAIL stall_stable: got reg/val change while valid expected none"); end
        ready_delay = 0;
    endtask

    task automatic test_retry();
        bit to;
        clear_table();
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1100;
        done_lat = 4;
        for (int n = 3; n <= 4; n++) begin
            nack_plan[1] = n;
            run_seq(1'b1, to);
            checks++;
            if (to || acc_q.size() !== 5) begin
                errors++; $display("FAIL retry%0d_count: timeout %0d got %0d writes expected 5", n, to, acc_q.size());
            end else begin
                for (int i = 1; i < 5; i++) begin
                    checks++;
                    if (acc_q[i] !== 24'h011100) begin errors++; $display("FAIL retry%0d_write: idx %0d got %h expected 011100", n, i, acc_q[i]); end
                end
            end
            checks++;
            if ({config_done, fault} !== ((n == 3) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL retry%0d_outcome: got done/fault %b", n, {config_done, fault});
            end
        end
        checks++;
        if (fault_addr !== 8'h01) begin errors++; $display("FAIL retry_fault_addr: got %h expected 01", fault_addr); end
        repeat (40) @(negedge clk);
        checks++;
        if (acc_q.size() !== 5 || sccb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL retry_quiet: got %0d writes valid %b busy %b expected 5 0 0", acc_q.size(), sccb_valid, busy);
        end
    endtask

    task automatic test_delay();
        bit to;
        clear_table();
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1100;
        done_lat = 3;
        run_seq(1'b1, to);
        checks++;
        if (to || acc_q.size() !== 2 || rise_q.size() !== 2 || done_q.size() < 1) begin
            errors++; $display("FAIL delay_count: timeout %0d got %0d writes expected 2", to, acc_q.size());
        end else begin
            checks++;
            if (rise_q[1] - done_q[0] - 1 !== DELAY_CYCLES + 6) begin
                errors++; $display("FAIL delay_gap: got %0d cycles expected %0d", rise_q[1] - done_q[0] - 1, DELAY_CYCLES + 6);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to, got;
        clear_table();
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1100;
        done_lat = 10;
        run_seq(1'b0, to);
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (acc_q.size() > 0) begin got = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!got || busy !== 1'b1) begin errors++; $display("FAIL rstmid_inflight: got accept %0d busy %b expected 1 1", got, busy); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sccb_valid, ov_pwrdn, busy, ov_reset} !== 4'b0100) begin
            errors++; $display("FAIL rstmid_async: got valid/pwrdn/busy/reset %b expected 0100", {sccb_valid, ov_pwrdn, busy, ov_reset});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_addr !== 8'h00 || config_done !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got addr %h done %b expected 00 0", rom_addr, config_done); end
        run_seq(1'b1, to);
        checks++;
        if (to || acc_q.size() !== 2) begin
            errors++; $display("FAIL rstmid_replay: timeout %0d got %0d writes expected 2", to, acc_q.size());
        end else begin
            checks++;
            if (acc_q[0] !== 24'h001280 || acc_q[1] !== 24'h011100) begin
                errors++; $display("FAIL rstmid_writes: got %h %h expected 001280 011100", acc_q[0], acc_q[1]);
            end
        end
    endtask

    task automatic test_full_table();
        bit to;
        clear_table();
        for (int i = 0; i < 256; i++) rom_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
        ready_delay = 0; done_lat = 1;
        run_seq(1'b1, to);
        checks++;
        if (to || acc_q.size() !== 256) begin
            errors++; $display("FAIL full_count: timeout %0d got %0d writes expected 256", to, acc_q.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_write: idx %0d got %h expected %h", i, acc_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (rom_addr !== 8'hFF || config_done !== 1'b1) begin
            errors++; $display("FAIL full_end: got addr %h done %b expected ff 1", rom_addr, config_done);
        end
    endtask

    task automatic test_random();
        bit to;
        int len;
        for (int it = 0; it < 8; it++) begin
            clear_table();
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    rom_mem[i] = 16'hFFF0;
                end else begin
                    rom_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
                    if ($urandom_range(0, 3) == 0) nack_plan[i] = $urandom_range(1, 4);
                end
            end
            ready_delay = $urandom_range(0, 3);
            done_lat = $urandom_range(1, 8);
            start_with_done = 1'($urandom_range(0, 1));
            run_seq(1'b1, to);
            checks++;
            if (to || acc_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: timeout %0d got %0d writes expected %0d", it, to, acc_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_write: idx %0d got %h expected %h", it, i, acc_q[i], exp_q[i]); end
                end
            end
            checks++;
            if ({fault, config_done} !== {exp_fault, !exp_fault} || rom_addr !== 8'(exp_final)) begin
                errors++; $display("FAIL rand%0d_end: got fault %b done %b addr %h expected %b %b %h", it, fault, config_done, rom_addr, exp_fault, !exp_fault, 8'(exp_final));
            end
            if (exp_fault) begin
                checks++;
                if (fault_addr !== 8'(exp_final)) begin errors++; $display("FAIL rand%0d_fault_addr: got %h expected %h", it, fault_addr, 8'(exp_final)); end
            end
        end
        start_with_done = 1'b0;
    endtask

    initial begin
        clear_table();
        for (int i = 0; i < 256; i++) nack_left[i] = 0;
        test_reset();
        test_basic();
        test_ready_stall();
        test_retry();
        test_delay();
        test_reset_mid();
        test_full_table();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
